katana_motion: RTL and testbench

- Sits directly downstream of center_of_mass and upstream of game_logic.
- Consumes the once-per-frame centroid update (x_com_calc/y_com_calc/new_com) plus the start-of-frame tick.
- Produces a smoothed katana position, per-frame velocity, a tracking flag and a held "slash" event, so game_logic cuts fruit only on fast blade motion.

---
 rtl/katana_motion.sv | 127 ++++++++++++
 tb/tb_katana_motion.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/katana_motion.sv
// Katana blade tracker: EMA-smooths the per-frame centroid, derives per-update
// velocity, and raises a held slash event on fast blade motion.
module katana_motion #(
  parameter int SMOOTH_SHIFT = 1,
  parameter int SPEED_THRESH = 40,
  parameter int HOLD_FRAMES  = 4,
  parameter int MAX_MISS     = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        x_in,
  input  logic [9:0]         y_in,
  input  logic               com_valid_in,
  input  logic               frame_tick_in,
  output logic [10:0]        x_out,
  output logic [9:0]         y_out,
  output logic signed [11:0] dx_out,
  output logic signed [10:0] dy_out,
  output logic               tracking_out,
  output logic               update_out,
  output logic               slash_out,
  output logic               slash_start_out
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int MW = $clog2(MAX_MISS + 1);

  typedef enum logic {IDLE, TRACK} state_t;

  state_t         state, state_next;
  logic [HW-1:0]  hold_cnt;
  logic [MW-1:0]  miss_cnt, miss_next;
  logic           seen;
  logic           pending;
  logic           drop;
  logic           slash_hit;

  logic signed [11:0] diff_x, step_x;
  logic signed [10:0] diff_y, step_y;
  logic [11:0]        abs_dx;
  logic [10:0]        abs_dy;
  logic [12:0]        speed;

  assign tracking_out = (state == TRACK);

  // NOTE: every variable written in always_comb is defaulted first, so no path leaves it unassigned (no latch).
  always_comb begin
    diff_x     = signed'({1'b0, x_in}) - signed'({1'b0, x_out});
    diff_y     = signed'({1'b0, y_in}) - signed'({1'b0, y_out});
    step_x     = diff_x >>> SMOOTH_SHIFT;
    step_y     = diff_y >>> SMOOTH_SHIFT;
    abs_dx     = dx_out[11] ? 12'(-dx_out) : 12'(dx_out);
    abs_dy     = dy_out[10] ? 11'(-dy_out) : 11'(dy_out);
    speed      = {1'b0, abs_dx} + {2'b00, abs_dy};
    slash_hit  = pending && (speed >= 13'(SPEED_THRESH));
    miss_next  = (seen || com_valid_in) ? '0 : miss_cnt + MW'(1);
    drop       = (state == TRACK) && frame_tick_in && (miss_next == MW'(MAX_MISS));
    state_next = state;
    case (state)
      IDLE:    if (com_valid_in) state_next = TRACK;
      TRACK:   if (drop)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      x_out           <= '0;
      y_out           <= '0;
      dx_out          <= '0;
      dy_out          <= '0;
      update_out      <= 1'b0;
      slash_out       <= 1'b0;
      slash_start_out <= 1'b0;
      hold_cnt        <= '0;
      miss_cnt        <= '0;
      seen            <= 1'b0;
      pending         <= 1'b0;
    end else begin
      state           <= state_next;
      update_out      <= 1'b0;
      slash_start_out <= 1'b0;
      pending         <= 1'b0;
      seen            <= frame_tick_in ? 1'b0 : (seen | com_valid_in);

      // Stage 2: a fresh detection reloads the hold even on a tick cycle.
      if (slash_hit) begin
        hold_cnt        <= HW'(HOLD_FRAMES);
        slash_out       <= 1'b1;
        slash_start_out <= ~slash_out;
      end else if (frame_tick_in && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) slash_out <= 1'b0;
      end

      if (state == TRACK && frame_tick_in) miss_cnt <= miss_next;

      if (drop) begin
        dx_out          <= '0;
        dy_out          <= '0;
        slash_out       <= 1'b0;
        slash_start_out <= 1'b0;
        hold_cnt        <= '0;
        miss_cnt        <= '0;
      end else if (com_valid_in) begin
        update_out <= 1'b1;
        if (state == IDLE) begin
          x_out    <= x_in;
          y_out    <= y_in;
          dx_out   <= '0;
          dy_out   <= '0;
          miss_cnt <= '0;
        end else begin
          // The smoothed point always lies between s and raw, so truncation is exact.
          x_out   <= x_out + step_x[10:0];
          y_out   <= y_out + step_y[9:0];
          dx_out  <= step_x;
          dy_out  <= step_y;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_katana_motion.sv
// Bench for katana_motion: per-cycle comparison against an integer reference
// model plus directed literal expectations.
module tb_katana_motion;

  localparam int SMOOTH_SHIFT = 1;
  localparam int SPEED_THRESH = 40;
  localparam int HOLD_FRAMES  = 4;
  localparam int MAX_MISS     = 8;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic [10:0]        x_in = '0;
  logic [9:0]         y_in = '0;
  logic               com_valid_in = 1'b0;
  logic               frame_tick_in = 1'b0;
  logic [10:0]        x_out;
  logic [9:0]         y_out;
  logic signed [11:0] dx_out;
  logic signed [10:0] dy_out;
  logic               tracking_out, update_out, slash_out, slash_start_out;

  int errors = 0;
  int checks = 0;

  katana_motion #(
    .SMOOTH_SHIFT(SMOOTH_SHIFT), .SPEED_THRESH(SPEED_THRESH),
    .HOLD_FRAMES(HOLD_FRAMES), .MAX_MISS(MAX_MISS)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .com_valid_in(com_valid_in), .frame_tick_in(frame_tick_in),
    .x_out(x_out), .y_out(y_out), .dx_out(dx_out), .dy_out(dy_out),
    .tracking_out(tracking_out), .update_out(update_out),
    .slash_out(slash_out), .slash_start_out(slash_start_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Floor division by 2^SMOOTH_SHIFT, i.e. the exact EMA step rounded toward -inf.
  function automatic int floor_step(input int d);
    int div;
    div = 1 << SMOOTH_SHIFT;
    if (d >= 0) return d / div;
    return -((-d + div - 1) / div);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model: plain integers, updated once per clock from the sampled inputs.
  int m_x, m_y, m_dx, m_dy, m_hold, m_miss, m_pend;
  bit m_track, m_upd, m_slash, m_start, m_seen, m_drop;
  bit chk_en = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_hold = 0; m_miss = 0; m_pend = -1;
      m_track = 0; m_upd = 0; m_slash = 0; m_start = 0; m_seen = 0;
      chk_en = 1'b1;
    end else begin
      m_upd = 0;
      m_start = 0;
      if (m_pend >= SPEED_THRESH) begin
        m_start = !m_slash;
        m_slash = 1;
        m_hold  = HOLD_FRAMES;
      end else if (frame_tick_in && m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_slash = 0;
      end
      m_pend = -1;
      m_drop = 0;
      if (frame_tick_in && m_track) begin
        if (m_seen || com_valid_in) m_miss = 0;
        else m_miss++;
        m_drop = (m_miss == MAX_MISS);
      end
      m_seen = frame_tick_in ? 1'b0 : (m_seen || com_valid_in);
      if (m_drop) begin
        m_track = 0; m_dx = 0; m_dy = 0; m_slash = 0; m_start = 0; m_hold = 0; m_miss = 0;
      end else if (com_valid_in) begin
        m_upd = 1;
        if (!m_track) begin
          m_x = int'(x_in); m_y = int'(y_in); m_dx = 0; m_dy = 0; m_track = 1; m_miss = 0;
        end else begin
          m_dx = floor_step(int'(x_in) - m_x);
          m_dy = floor_step(int'(y_in) - m_y);
          m_x += m_dx;
          m_y += m_dy;
          m_pend = iabs(m_dx) + iabs(m_dy);
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("cyc_x",     int'(x_out),           m_x);
      check("cyc_y",     int'(y_out),           m_y);
      check("cyc_dx",    int'(dx_out),          m_dx);
      check("cyc_dy",    int'(dy_out),          m_dy);
      check("cyc_track", int'(tracking_out),    int'(m_track));
      check("cyc_upd",   int'(update_out),      int'(m_upd));
      check("cyc_slash", int'(slash_out),       int'(m_slash));
      check("cyc_start", int'(slash_start_out), int'(m_start));
    end
  end

  task automatic cyc(input bit cv, input int x, input int y, input bit tk, input bit r);
    com_valid_in  = cv;
    x_in          = 11'(x);
    y_in          = 10'(y);
    frame_tick_in = tk;
    rst_in        = r;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    cyc(0, 0, 0, 1, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("rst_track", int'(tracking_out), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_slash", int'(slash_out), 0);

    // First sample loads raw.
    cyc(1, 100, 200, 0, 0);
    check("load_x", int'(x_out), 100);
    check("load_y", int'(y_out), 200);
    check("load_dx", int'(dx_out), 0);
    check("load_track", int'(tracking_out), 1);
    check("load_upd", int'(update_out), 1);
    idle();
    check("load_noslash", int'(slash_out), 0);

    cyc(1, 160, 200, 0, 0);
    check("slow_x", int'(x_out), 130);
    check("slow_dx", int'(dx_out), 30);
    idle();
    check("slow_noslash", int'(slash_out), 0);

    cyc(1, 260, 200, 0, 0);
    check("fast_x", int'(x_out), 195);
    check("fast_dx", int'(dx_out), 65);
    idle();
    check("fast_start", int'(slash_start_out), 1);
    check("fast_slash", int'(slash_out), 1);
    idle();
    check("fast_start_once", int'(slash_start_out), 0);

    // Held through exactly four ticks.
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
    end
    check("hold3_slash", int'(slash_out), 1);
    tick();
    check("hold4_drop", int'(slash_out), 0);

    cyc(1, 95, 200, 0, 0);
    check("neg_x", int'(x_out), 145);
    check("neg_dx", int'(dx_out), -50);
    idle();
    check("neg_start", int'(slash_start_out), 1);

    // 1 >>> 1 floors to 0.
    cyc(1, 146, 201, 0, 0);
    check("floor_dx", int'(dx_out), 0);
    check("floor_dy", int'(dy_out), 0);
    check("floor_x", int'(x_out), 145);
    check("floor_y", int'(y_out), 200);

    // Retrigger with hold_cnt=1; reload coincides with a tick.
    tick(); tick(); tick();
    check("retrig_pre_slash", int'(slash_out), 1);
    cyc(1, 245, 200, 0, 0);
    check("retrig_dx", int'(dx_out), 50);
    tick();
    check("retrig_no_start", int'(slash_start_out), 0);
    check("retrig_slash", int'(slash_out), 1);
    tick(); tick(); tick();
    check("retrig_hold", int'(slash_out), 1);
    tick();
    check("retrig_drop", int'(slash_out), 0);

    // Update coincident with a tick resets the miss count; drop needs 8 more ticks.
    cyc(1, 195, 200, 1, 0);
    for (int i = 0; i < 7; i++) tick();
    check("miss7_track", int'(tracking_out), 1);
    tick();
    check("miss8_track", int'(tracking_out), 0);
    check("miss8_dx", int'(dx_out), 0);
    check("miss8_x", int'(x_out), 195);
    check("miss8_slash", int'(slash_out), 0);

    tick();
    check("idle_tick_track", int'(tracking_out), 0);
    cyc(1, 500, 300, 0, 0);
    check("reload_x", int'(x_out), 500);
    check("reload_dx", int'(dx_out), 0);
    check("reload_track", int'(tracking_out), 1);

    // Reset during a slash with a pending stage-2 evaluation.
    cyc(1, 600, 300, 0, 0);
    check("pre_rst_x", int'(x_out), 550);
    idle();
    check("pre_rst_slash", int'(slash_out), 1);
    cyc(1, 700, 300, 0, 0);
    check("pre_rst_dx", int'(dx_out), 75);
    cyc(0, 0, 0, 0, 1);
    check("rst_mid_x", int'(x_out), 0);
    check("rst_mid_dx", int'(dx_out), 0);
    check("rst_mid_slash", int'(slash_out), 0);
    check("rst_mid_start", int'(slash_start_out), 0);
    check("rst_mid_track", int'(tracking_out), 0);
    idle();
    check("rst_post_start", int'(slash_start_out), 0);
    check("rst_post_slash", int'(slash_out), 0);

    // Extreme coordinates: full-range negative step.
    cyc(1, 1023, 767, 0, 0);
    check("edge_load_x", int'(x_out), 1023);
    cyc(1, 0, 0, 0, 0);
    check("edge_dx", int'(dx_out), -512);
    check("edge_dy", int'(dy_out), -384);
    check("edge_x", int'(x_out), 511);
    check("edge_y", int'(y_out), 383);
    idle();
    check("edge_start", int'(slash_start_out), 1);
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
